// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fetch_unit: instruction-fetch stage and producer side of the IF/ID register.
//
// Holds the PC and issues one-outstanding, level-held requests to a
// multi-cycle instruction memory. Buffers the returned instruction and presents
// it to IF/ID as {instruction, PC+2, flush}. Obeys the hazard-unit stall
// (stall_n). Applies ID-stage redirects, which squash any in-flight fetch by
// draining the stale response. Parks in HALT on an HLT opcode.
//
// Optional build macro FETCH_PERF_EN adds two saturating performance counters:
//   perf_fetched : instructions consumed by IF/ID
//   perf_bubbles : IF/ID write cycles that captured a bubble
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_n,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] fetch_instr,
  output logic [15:0] fetch_pc,
  output logic        fetch_flush,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_bubbles
`endif
);

  // FETCH: request outstanding at pc.
  // HOLD : instruction buffered for IF/ID.
  // DRAIN: squashed request still in flight.
  // HALT : parked.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q,      state_d;
  logic [15:0] pc_q,         pc_d;
  logic [15:0] req_addr_q,   req_addr_d;
  logic [15:0] ibuf_q,       ibuf_d;
  logic [15:0] ibuf_pc_q,    ibuf_pc_d;
  logic        ibuf_valid_q, ibuf_valid_d;

  // Next-state and datapath update; a redirect outranks stall, response and HLT.
  always_comb begin
    // NOTE: every _d gets a hold-value default first, so no path through the
    // case below can leave a signal unassigned and infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    ibuf_d       = ibuf_q;
    ibuf_pc_d    = ibuf_pc_q;
    ibuf_valid_d = ibuf_valid_q;

    unique case (state_q)
      S_FETCH: begin
        // Remember the address on the bus in case a redirect forces a drain.
        req_addr_d = pc_q;
        if (branch_taken) begin
          pc_d         = branch_target;
          ibuf_valid_d = 1'b0;
          // A response landing in the same cycle closes the request at once.
          state_d      = imem_valid ? S_FETCH : S_DRAIN;
        end else if (imem_valid) begin
          ibuf_d       = imem_rdata;
          ibuf_pc_d    = pc_q;
          ibuf_valid_d = 1'b1;
          pc_d         = pc_q + 16'd2;
          state_d      = S_HOLD;
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          // A squash wins even while IF/ID is stalled, and it kills a buffered HLT.
          pc_d         = branch_target;
          ibuf_valid_d = 1'b0;
          state_d      = S_FETCH;
        end else if (stall_n) begin
          ibuf_valid_d = 1'b0;
          state_d      = (ibuf_q[15:12] == HLT_OPCODE) ? S_HALT : S_FETCH;
        end
      end

      S_DRAIN: begin
        if (branch_taken) begin
          // Later redirects just retarget; the stale request still has to finish.
          pc_d    = branch_target;
          state_d = imem_valid ? S_FETCH : S_DRAIN;
        end else if (imem_valid) begin
          state_d = S_FETCH;
        end
      end

      S_HALT: begin
        // Absorbing: only rst leaves this state; redirects are ignored.
        ibuf_valid_d = 1'b0;
      end

      default: begin
        state_d      = S_FETCH;
        ibuf_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the same pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ibuf_valid_q <= 1'b0;
      // NOTE: only ibuf_valid matters functionally here; the datapath is reset
      // as well so nothing downstream ever observes X after reset.
      req_addr_q   <= 16'h0000;
      ibuf_q       <= NOP_INSTR;
      ibuf_pc_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      ibuf_q       <= ibuf_d;
      ibuf_pc_q    <= ibuf_pc_d;
      ibuf_valid_q <= ibuf_valid_d;
    end
  end

  // Memory interface: request is level-held in FETCH and DRAIN, masked during reset.
  always_comb begin
    imem_req  = ~rst & ((state_q == S_FETCH) | (state_q == S_DRAIN));
    imem_addr = (state_q == S_DRAIN) ? req_addr_q : pc_q;
  end

  // IF/ID presentation: a bubble whenever nothing valid is buffered.
  always_comb begin
    fetch_instr = ibuf_valid_q ? ibuf_q : NOP_INSTR;
    fetch_pc    = ibuf_valid_q ? (ibuf_pc_q + 16'd2) : 16'h0000;
    fetch_flush = ~ibuf_valid_q;
    halted      = (state_q == S_HALT);
  end

`ifdef FETCH_PERF_EN
  logic        consume;
  logic        bubble;
  logic [15:0] perf_fetched_q;
  logic [15:0] perf_bubbles_q;

  assign consume = (state_q == S_HOLD) & stall_n & ~branch_taken;
  assign bubble  = stall_n & ~ibuf_valid_q;

  // Saturating counters of consumed instructions and captured bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= 16'h0000;
      perf_bubbles_q <= 16'h0000;
    end else begin
      if (consume && (perf_fetched_q != 16'hFFFF)) perf_fetched_q <= perf_fetched_q + 16'd1;
      if (bubble  && (perf_bubbles_q != 16'hFFFF)) perf_bubbles_q <= perf_bubbles_q + 16'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fetch_unit: directed scenarios plus a randomized program-order scoreboard
// for fetch_unit. The memory responder gives a fixed or random latency. Its
// data is a pure function of the address.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_n = 1'b1;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_valid = 1'b0;
  logic [15:0] fetch_instr;
  logic [15:0] fetch_pc;
  logic        fetch_flush;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_bubbles;
`endif

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall_n      (stall_n),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .fetch_instr  (fetch_instr),
    .fetch_pc     (fetch_pc),
    .fetch_flush  (fetch_flush),
    .halted       (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory model: override table, else an address hash that never yields HLT.
  logic [15:0] mem_ovr [logic [15:0]];
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  int          lat_cfg  = 1;
  logic [15:0] mem_addr = 16'h0000;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    logic [15:0] d;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    d = a * 16'h9E37 + 16'h1234;
    if (d[15:12] == 4'hF) d[15:12] = 4'h7;
    return d;
  endfunction

  // One clock: called at a negedge. Drives the inputs and the memory response,
  // then returns at the next negedge.
  task automatic step(input logic st, input logic br, input logic [15:0] tgt);
    stall_n       = st;
    branch_taken  = br;
    branch_target = tgt;
    imem_valid    = 1'b0;
    imem_rdata    = 16'($urandom);
    if (rst) begin
      mem_busy = 1'b0;
    end else if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
      end else begin
        if (imem_addr !== mem_addr) begin
          errors++;
          $display("FAIL addr_stable: imem_addr=%h required %h", imem_addr, mem_addr);
        end
        checks++;
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem_fn(mem_addr);
          mem_busy   = 1'b0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    rst = 1'b0;
    mem_busy = 1'b0;
    #1;
  endtask

  // Bounded wait until an instruction is presented to IF/ID.
  task automatic wait_present(input string name);
    for (int i = 0; i < 20 && fetch_flush; i++) step(1'b1, 1'b0, 16'h0000);
    if (fetch_flush !== 1'b0) begin
      errors++;
      $display("FAIL %s: no instruction presented within 20 cycles", name);
    end
    checks++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 1'b0, 16'h0000);
    if ({imem_req, fetch_flush, halted} !== 3'b010) begin
      errors++;
      $display("FAIL reset_ctl: req/flush/halted=%b required 010", {imem_req, fetch_flush, halted});
    end
    checks++;
    if ({fetch_instr, fetch_pc} !== 32'h0000_0000) begin
      errors++;
      $display("FAIL reset_data: instr/pc=%h required 00000000", {fetch_instr, fetch_pc});
    end
    checks++;
    step(1'b1, 1'b0, 16'h0000);
    rst = 1'b0;
    mem_busy = 1'b0;
    #1;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL reset_first_req: req/addr=%h required 10000", {imem_req, imem_addr});
    end
    checks++;
  endtask

  task automatic test_basic_fetch();
    mem_ovr.delete();
    mem_ovr[16'h0000] = 16'h1234;
    lat_cfg = 1;
    do_reset();
    step(1'b1, 1'b0, 16'h0000);
    if (fetch_flush !== 1'b1) begin
      errors++;
      $display("FAIL basic_wait: flush=%b required 1", fetch_flush);
    end
    checks++;
    step(1'b1, 1'b0, 16'h0000);
    if ({fetch_instr, fetch_pc, fetch_flush, imem_req} !== {16'h1234, 16'h0002, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_present: instr=%h pc=%h flush=%b req=%b required 1234 0002 0 0",
               fetch_instr, fetch_pc, fetch_flush, imem_req);
    end
    checks++;
    step(1'b1, 1'b0, 16'h0000);
    if ({imem_req, imem_addr, fetch_flush} !== {1'b1, 16'h0002, 1'b1}) begin
      errors++;
      $display("FAIL basic_next: req=%b addr=%h flush=%b required 1 0002 1", imem_req, imem_addr, fetch_flush);
    end
    checks++;
  endtask

  task automatic test_stall();
    mem_ovr.delete();
    lat_cfg = 2;
    do_reset();
    wait_present("stall_wait");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h0000);
      if ({fetch_instr, fetch_pc, fetch_flush, imem_req} !== {mem_fn(16'h0000), 16'h0002, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold%0d: instr=%h pc=%h flush=%b req=%b required %h 0002 0 0",
                 i, fetch_instr, fetch_pc, fetch_flush, imem_req, mem_fn(16'h0000));
      end
      checks++;
    end
    step(1'b1, 1'b0, 16'h0000);
    if ({fetch_flush, imem_req, imem_addr} !== {1'b1, 1'b1, 16'h0002}) begin
      errors++;
      $display("FAIL stall_release: flush=%b req=%b addr=%h required 1 1 0002", fetch_flush, imem_req, imem_addr);
    end
    checks++;
  endtask

  task automatic test_branch_squash();
    mem_ovr.delete();
    lat_cfg = 1;
    do_reset();
    wait_present("squash_w0");
    step(1'b1, 1'b0, 16'h0000);
    wait_present("squash_w2");
    step(1'b1, 1'b0, 16'h0000);
    if ({imem_req, imem_addr} !== {1'b1, 16'h0004}) begin
      errors++;
      $display("FAIL squash_req4: req=%b addr=%h required 1 0004", imem_req, imem_addr);
    end
    checks++;
    lat_cfg = 2;
    step(1'b1, 1'b1, 16'h0040);
    for (int i = 0; i < 2; i++) begin
      if ({imem_req, imem_addr, fetch_flush} !== {1'b1, 16'h0004, 1'b1}) begin
        errors++;
        $display("FAIL squash_drain%0d: req=%b addr=%h flush=%b required 1 0004 1",
                 i, imem_req, imem_addr, fetch_flush);
      end
      checks++;
      step(1'b1, 1'b0, 16'h0000);
    end
    if ({imem_req, imem_addr, fetch_flush} !== {1'b1, 16'h0040, 1'b1}) begin
      errors++;
      $display("FAIL squash_redirect: req=%b addr=%h flush=%b required 1 0040 1", imem_req, imem_addr, fetch_flush);
    end
    checks++;
    lat_cfg = 1;
    wait_present("squash_w40");
    if ({fetch_instr, fetch_pc} !== {mem_fn(16'h0040), 16'h0042}) begin
      errors++;
      $display("FAIL squash_target: instr=%h pc=%h required %h 0042", fetch_instr, fetch_pc, mem_fn(16'h0040));
    end
    checks++;
  endtask

  task automatic test_halt();
    mem_ovr.delete();
    mem_ovr[16'h0000] = 16'hF000;
    lat_cfg = 1;
    do_reset();
    wait_present("halt_wait");
    if (fetch_instr !== 16'hF000) begin
      errors++;
      $display("FAIL halt_instr: instr=%h required f000", fetch_instr);
    end
    checks++;
    step(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      if ({halted, imem_req, fetch_flush, fetch_instr} !== {3'b101, 16'h0000}) begin
        errors++;
        $display("FAIL halt_park%0d: halted=%b req=%b flush=%b instr=%h required 1 0 1 0000",
                 i, halted, imem_req, fetch_flush, fetch_instr);
      end
      checks++;
      step(i[0], ~i[0], 16'h0100 + 16'(i * 2));
    end
  endtask

  task automatic test_halt_branch();
    mem_ovr.delete();
    mem_ovr[16'h0000] = 16'hF000;
    lat_cfg = 1;
    do_reset();
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_exit_rst: halted=%b required 0", halted);
    end
    checks++;
    wait_present("hbr_wait");
    step(1'b1, 1'b1, 16'h0010);
    if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0010}) begin
      errors++;
      $display("FAIL halt_squashed: halted=%b req=%b addr=%h required 0 1 0010", halted, imem_req, imem_addr);
    end
    checks++;
    wait_present("hbr_w10");
    if ({fetch_instr, fetch_pc} !== {mem_fn(16'h0010), 16'h0012}) begin
      errors++;
      $display("FAIL halt_br_target: instr=%h pc=%h required %h 0012", fetch_instr, fetch_pc, mem_fn(16'h0010));
    end
    checks++;
  endtask

  task automatic test_wrap_and_reset();
    mem_ovr.delete();
    lat_cfg = 1;
    do_reset();
    wait_present("wrap_w0");
    step(1'b1, 1'b1, 16'hFFFE);
    if ({imem_req, imem_addr} !== {1'b1, 16'hFFFE}) begin
      errors++;
      $display("FAIL wrap_req: req=%b addr=%h required 1 fffe", imem_req, imem_addr);
    end
    checks++;
    wait_present("wrap_wfffe");
    if ({fetch_instr, fetch_pc, fetch_flush} !== {mem_fn(16'hFFFE), 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL wrap_pc: instr=%h pc=%h flush=%b required %h 0000 0",
               fetch_instr, fetch_pc, fetch_flush, mem_fn(16'hFFFE));
    end
    checks++;
    step(1'b1, 1'b0, 16'h0000);
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_next: req=%b addr=%h required 1 0000", imem_req, imem_addr);
    end
    checks++;
    wait_present("wrap_w0b");
    step(1'b1, 1'b0, 16'h0000);
    lat_cfg = 3;
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    if ({imem_req, imem_addr} !== {1'b1, 16'h0002}) begin
      errors++;
      $display("FAIL midreq_pending: req=%b addr=%h required 1 0002", imem_req, imem_addr);
    end
    checks++;
    rst = 1'b1;
    #1;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL midreq_rst_req: req=%b required 0", imem_req);
    end
    checks++;
    step(1'b1, 1'b0, 16'h0000);
    if ({imem_req, fetch_flush} !== 2'b01) begin
      errors++;
      $display("FAIL midreq_rst_hold: req=%b flush=%b required 0 1", imem_req, fetch_flush);
    end
    checks++;
    rst = 1'b0;
    mem_busy = 1'b0;
    #1;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL midreq_restart: req=%b addr=%h required 1 0000", imem_req, imem_addr);
    end
    checks++;
    lat_cfg = 1;
    wait_present("midreq_w0");
    if ({fetch_instr, fetch_pc} !== {mem_fn(16'h0000), 16'h0002}) begin
      errors++;
      $display("FAIL midreq_first: instr=%h pc=%h required %h 0002", fetch_instr, fetch_pc, mem_fn(16'h0000));
    end
    checks++;
  endtask

  // Program-order scoreboard: each presented instruction must be the one at
  // the next address of the architectural stream. That stream advances by 2 on
  // every consume and restarts at the target on every redirect.
  task automatic test_random();
    logic [15:0] exp_pc;
    logic [15:0] exp_pc2;
    logic        st;
    logic        br;
    logic [15:0] tgt;
    int          consumed;
    mem_ovr.delete();
    lat_cfg  = 0;
    do_reset();
    exp_pc   = 16'h0000;
    consumed = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      exp_pc2 = exp_pc + 16'd2;
      if (imem_req && !mem_busy) begin
        if (imem_addr !== exp_pc) begin
          errors++;
          $display("FAIL rnd_req_addr cyc%0d: addr=%h required %h", cyc, imem_addr, exp_pc);
        end
        checks++;
      end
      if (halted !== 1'b0) begin
        errors++;
        $display("FAIL rnd_halted cyc%0d: halted=%b required 0", cyc, halted);
      end
      checks++;
      if (fetch_flush === 1'b0) begin
        if ({fetch_instr, fetch_pc} !== {mem_fn(exp_pc), exp_pc2}) begin
          errors++;
          $display("FAIL rnd_present cyc%0d: instr=%h pc=%h required %h %h",
                   cyc, fetch_instr, fetch_pc, mem_fn(exp_pc), exp_pc2);
        end
        checks++;
      end
      st  = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 11) == 0);
      tgt = 16'($urandom) & 16'hFFFE;
      if (br) begin
        exp_pc = tgt;
      end else if ((fetch_flush === 1'b0) && st) begin
        exp_pc = exp_pc2;
        consumed++;
      end
      step(st, br, tgt);
    end
    if (consumed < 100) begin
      errors++;
      $display("FAIL rnd_progress: consumed=%0d required >= 100", consumed);
    end
    checks++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_fetch();
    test_stall();
    test_branch_squash();
    test_halt();
    test_halt_branch();
    test_wrap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
